// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared 32-step shift-add /
// restoring-divide datapath, stalling EX while busy and pulsing done with a registered result.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        sa;
    logic        sb;
    logic [4:0]  count;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        signed_a;
    logic        signed_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_result;

    logic        is_div;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [31:0] step_hi;
    logic [31:0] step_lo;
    logic [63:0] product;
    logic [63:0] prod_s;
    logic [31:0] mul_res;
    logic [31:0] quot;
    logic [31:0] remv;
    logic [31:0] final_result;

    // Operand decode and special-case detection, used only on acceptance in IDLE.
    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a    = signed_a && rs1[31];
        neg_b    = signed_b && rs2[31];
        mag_a    = neg_a ? (~rs1 + 32'd1) : rs1;
        mag_b    = neg_b ? (~rs2 + 32'd1) : rs2;
        div_zero = funct3[2] && (rs2 == 32'd0);
        div_ovf  = funct3[2] && !funct3[0] &&
                   (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_result = funct3[1] ? rs1 : 32'hFFFF_FFFF;
        else
            special_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration: {hi,lo} is the 64-bit product shifting right for multiply,
    // or partial remainder / dividend-becoming-quotient shifting left for divide.
    always_comb begin
        is_div    = op[2];
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : 33'd0);
        div_shift = {hi, lo[31]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[31:0] - opb;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[31:0];
            step_lo = {lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], lo[31:1]};
        end
        product      = {step_hi, step_lo};
        prod_s       = (sa ^ sb) ? (~product + 64'd1) : product;
        mul_res      = (op == 3'b000) ? prod_s[31:0] : prod_s[63:32];
        quot         = (sa ^ sb) ? (~step_lo + 32'd1) : step_lo;
        remv         = sa ? (~step_hi + 32'd1) : step_hi;
        final_result = is_div ? (op[1] ? remv : quot) : mul_res;
    end

    assign stall = ((state == IDLE) && start && !flush) || (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= 3'd0;
            opa    <= 32'd0;
            opb    <= 32'd0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            count  <= 5'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
            result <= 32'd0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op    <= funct3;
                        opa   <= mag_a;
                        opb   <= mag_b;
                        sa    <= neg_a;
                        sb    <= neg_b;
                        count <= 5'd0;
                        hi    <= 32'd0;
                        lo    <= funct3[2] ? mag_a : mag_b;
                        err   <= special;
                        if (special) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= special_result;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        count <= 5'd0;
                    end else begin
                        hi    <= step_hi;
                        lo    <= step_lo;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= final_result;
                            count  <= 5'd0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq: hand-computed RV32M results, latency,
// stall shape, flush and asynchronous reset behaviour.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        err;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3 = f;
        rs1    = a;
        rs2    = b;
        flush  = 1'b0;
        start  = 1'b1;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; that clock cycle is cycle 0 of the operation.
    task automatic runOp(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_err, input int exp_lat);
        int   lat;
        logic stall_ok;
        applyStimulus(f, a, b);
        checkOutput({tag, " stall c0"}, {31'd0, stall}, 32'd1);
        lat      = 0;
        stall_ok = 1'b1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            nextCycle();
            if (done) lat = c;
            else if (!stall) stall_ok = 1'b0;
        end
        checkOutput({tag, " latency"}, lat, exp_lat);
        checkOutput({tag, " stall busy"}, {31'd0, stall_ok}, 32'd1);
        checkOutput({tag, " result"}, result, exp_res);
        checkOutput({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        checkOutput({tag, " stall done"}, {31'd0, stall}, 32'd0);
        start = 1'b0;
        nextCycle();
        checkOutput({tag, " done low"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " idle stall"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int saw_done;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        rst_n = 1'b1;
        nextCycle();

        runOp("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
        runOp("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        runOp("mulhsu", MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0, 33);
        runOp("mulhu", MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33);
        runOp("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        runOp("rem", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        runOp("divu", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
        runOp("remu", REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
        runOp("divu0", DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
        runOp("removf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
        runOp("divovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1);
        runOp("remu0", REMU, 32'd5, 32'd0, 32'd5, 1'b1, 1);

        // start together with flush in IDLE is not accepted
        applyStimulus(MUL, 32'd3, 32'd4);
        flush = 1'b1;
        #1;
        checkOutput("idle flush stall", {31'd0, stall}, 32'd0);
        nextCycle();
        checkOutput("idle flush not accepted", {31'd0, stall}, 32'd0);
        start = 1'b0;
        flush = 1'b0;
        nextCycle();

        // flush in BUSY cycle 10
        applyStimulus(DIV, 32'd100, 32'd7);
        repeat (10) nextCycle();
        checkOutput("flush busy c10", {31'd0, stall}, 32'd1);
        flush = 1'b1;
        start = 1'b0;
        nextCycle();
        checkOutput("flush idle c11", {31'd0, stall}, 32'd0);
        checkOutput("flush done c11", {31'd0, done}, 32'd0);
        checkOutput("flush result kept", result, 32'd5);
        flush    = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 40; c++) begin
            nextCycle();
            if (done) saw_done = 1;
        end
        checkOutput("flush no done", saw_done, 0);
        runOp("mul after flush", MUL, 32'd3, 32'd4, 32'd12, 1'b0, 33);

        // asynchronous reset in BUSY cycle 15, start held through release
        applyStimulus(DIVU, 32'd100, 32'd7);
        repeat (15) nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst done", {31'd0, done}, 32'd0);
        checkOutput("rst result", result, 32'd0);
        checkOutput("rst err", {31'd0, err}, 32'd0);
        nextCycle();
        checkOutput("rst idle stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b1;
        runOp("divu after rst", DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
